// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, issues eight word reads for the
// missing 16-byte block and writes the returned words into the data array.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data,
  output logic        fsm_busy,
  output logic        memory_enable,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        write_tag_array,
  output logic [11:0] fill_block
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_req_cnt;
  logic [3:0]  r_rcv_cnt;
  logic [11:0] r_fill_block;
  logic        w_req_active;
  logic        w_rcv;

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_cnt    <= '0;
      r_rcv_cnt    <= '0;
      r_fill_block <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (miss_detected) begin
            r_fill_block <= miss_address[15:4];
            r_req_cnt    <= '0;
            r_rcv_cnt    <= '0;
          end
        end
        S_FILL: begin
          if (w_req_active) r_req_cnt <= r_req_cnt + 4'd1;
          if (w_rcv)        r_rcv_cnt <= r_rcv_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_req_active     = 1'b0;
    w_rcv            = 1'b0;
    fsm_busy         = 1'b0;
    memory_enable    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    write_tag_array  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (miss_detected) w_next_state = S_FILL;
      end
      S_FILL: begin
        fsm_busy     = 1'b1;
        w_req_active = ~r_req_cnt[3];
        w_rcv        = memory_data_valid;
        if (w_req_active) begin
          memory_enable  = 1'b1;
          memory_address = {r_fill_block, r_req_cnt[2:0], 1'b0};
        end
        // Words return in request order, so the valid count is the word index.
        if (w_rcv) begin
          write_data_array = 1'b1;
          fill_word        = r_rcv_cnt[2:0];
          if (r_rcv_cnt == 4'd7) begin
            write_tag_array = 1'b1;
            w_next_state    = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign fill_data  = memory_data;
  assign fill_block = r_fill_block;

endmodule
